branch_resolution_queue: RTL

Downstream companion to the perceptron branch predictor. Holds each issued prediction (IP plus predicted direction) in order until the branch resolves, compares it against the actual outcome, and on a mispredict pulses a flush, discards all younger wrong-path predictions, and stalls intake for a fixed recovery window. It also keeps saturating accuracy counters for the performance bench.

---
 rtl/branch_resolution_queue.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/branch_resolution_queue.sv
// In-order queue of issued branch predictions, checked against resolved outcomes.
// A mispredict flushes the queue, pulses for one cycle and blocks intake for RECOVER cycles.
module branch_resolution_queue #(
    parameter int DEPTH   = 8,
    parameter int RECOVER = 2,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pred_valid,
    input  logic [63:0]                pred_ip,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       mispredict,
    output logic [63:0]                mispredict_ip,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           total_count,
    output logic [CNT_W-1:0]           correct_count,
    output logic                       underflow_err,
    output logic                       overflow_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_RECOVER = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [63:0]      r_mem_ip    [DEPTH];
    logic             r_mem_taken [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_occ;
    state_t           r_state;
    logic [3:0]       r_rec_cnt;
    logic             r_mispredict;
    logic [63:0]      r_mis_ip;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_correct;
    logic             r_underflow;
    logic             r_overflow;

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_hit;
    logic w_mis;

    assign w_ready = (r_state == ST_RUN) && (r_occ != OCC_W'(DEPTH));
    assign w_push  = pred_valid && w_ready;
    assign w_pop   = res_valid && (r_occ != OCC_W'(0));
    assign w_hit   = (r_mem_taken[r_rd_ptr] == res_taken);
    assign w_mis   = w_pop && !w_hit;

    assign pred_ready    = w_ready;
    assign mispredict    = r_mispredict;
    assign mispredict_ip = r_mis_ip;
    assign occupancy     = r_occ;
    assign total_count   = r_total;
    assign correct_count = r_correct;
    assign underflow_err = r_underflow;
    assign overflow_err  = r_overflow;

    // Entry storage; stale slots are harmless because pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ip[r_wr_ptr]    <= pred_ip;
            r_mem_taken[r_wr_ptr] <= pred_taken;
        end
    end

    // Pointers, state, recovery timer, statistics and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_occ        <= '0;
            r_state      <= ST_RUN;
            r_rec_cnt    <= 4'd0;
            r_mispredict <= 1'b0;
            r_mis_ip     <= 64'd0;
            r_total      <= '0;
            r_correct    <= '0;
            r_underflow  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_total <= sat_inc(r_total);
                if (w_hit) begin
                    r_correct <= sat_inc(r_correct);
                end
            end
            if (res_valid && (r_occ == OCC_W'(0))) begin
                r_underflow <= 1'b1;
            end
            if ((r_state == ST_RUN) && pred_valid && !w_ready) begin
                r_overflow <= 1'b1;
            end
            r_mispredict <= w_mis;

            if (w_mis) begin
                // Flush discards any push accepted in this same cycle.
                r_mis_ip  <= r_mem_ip[r_rd_ptr];
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
                r_occ     <= '0;
                r_state   <= ST_RECOVER;
                r_rec_cnt <= 4'(RECOVER);
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_occ <= r_occ + OCC_W'(1);
                    2'b01:   r_occ <= r_occ - OCC_W'(1);
                    default: r_occ <= r_occ;
                endcase
                case (r_state)
                    ST_RECOVER: begin
                        if (r_rec_cnt <= 4'd1) begin
                            r_state   <= ST_RUN;
                            r_rec_cnt <= 4'd0;
                        end else begin
                            r_rec_cnt <= r_rec_cnt - 4'd1;
                        end
                    end
                    default: begin
                        r_state   <= ST_RUN;
                        r_rec_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end
endmodule
